ahb_bus_arbiter: RTL and testbench

- Three-master AHB arbiter.
- Owns the select lines for the shared address mux and the write-data mux.
- Decides which master drives the bus using round-robin priority, with burst, lock and tenure-limit rules.
- Issues registered grants and the address-phase select (hmaster). Issues a one-data-phase-delayed select (hmaster_data) for the write-data mux.

---
 rtl/ahb_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Three-master AHB arbiter: round-robin grant with burst protection, bus
// lock and a tenure limit; drives the address-mux and write-data-mux selects.
module ahb_bus_arbiter #(
  parameter logic [1:0]  MASTER1    = 2'b00,
  parameter logic [1:0]  MASTER2    = 2'b01,
  parameter logic [1:0]  MASTER3    = 2'b10,
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [2:0] hbusreq,
  input  logic [2:0] hlock,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic [2:0] hgrant,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_data,
  output logic       hmastlock
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 2;
  localparam logic [1:0]  TR_BUSY = 2'b01;
  localparam logic [1:0]  TR_SEQ  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TENURE - 1);

  // Round-robin pointer holds the index (0..2) of the last master that won.
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [CNT_W-1:0] tenure_cnt;
  logic [CNT_W-1:0] tenure_cnt_nxt;

  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] grant_idx_nxt;
  logic [IDX_W-1:0] win_idx;
  logic             win_hit;
  logic             owner_req;
  logic             owner_lock;
  logic             others_req;
  logic             rearb_ok;
  logic             lock_hold;
  logic             tenure_out;
  logic [2:0]       masked_req;

  // Map a master index onto its hmaster encoding.
  function automatic logic [1:0] enc_master(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd1:    enc_master = MASTER2;
      2'd2:    enc_master = MASTER3;
      default: enc_master = MASTER1;
    endcase
  endfunction

  // Arbitration decision and tenure bookkeeping for the next hready edge.
  always_comb begin
    owner_idx      = 2'd0;
    win_idx        = 2'd0;
    win_hit        = 1'b0;
    grant_idx_nxt  = 2'd0;
    rr_ptr_nxt     = rr_ptr;
    tenure_cnt_nxt = tenure_cnt;

    if (hgrant[1])      owner_idx = 2'd1;
    else if (hgrant[2]) owner_idx = 2'd2;

    owner_req  = hbusreq[owner_idx];
    owner_lock = hlock[owner_idx];
    others_req = |(hbusreq & ~hgrant);
    rearb_ok   = hready && (htrans != TR_BUSY) && (htrans != TR_SEQ);
    lock_hold  = owner_req && owner_lock;
    tenure_out = (tenure_cnt >= CNT_LIMIT);

    masked_req = hbusreq;
    if (tenure_out && !owner_lock) masked_req[owner_idx] = 1'b0;

    // Scan starting at the master after the pointer, wrapping 3 -> 1.
    for (int i = 1; i <= 3; i++) begin
      if (!win_hit && masked_req[(int'(rr_ptr) + i) % 3]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'((int'(rr_ptr) + i) % 3);
      end
    end

    grant_idx_nxt = owner_idx;
    if (rearb_ok && !lock_hold) begin
      if (win_hit) begin
        grant_idx_nxt = win_idx;
        if (win_idx != owner_idx) rr_ptr_nxt = win_idx;
      end else if (owner_req) begin
        grant_idx_nxt = owner_idx;
      end else begin
        grant_idx_nxt = 2'd0;
      end
    end

    if (grant_idx_nxt != owner_idx) begin
      tenure_cnt_nxt = '0;
    end else if (others_req) begin
      tenure_cnt_nxt = (tenure_cnt == CNT_MAX) ? tenure_cnt : tenure_cnt + CNT_W'(1);
    end else begin
      tenure_cnt_nxt = '0;
    end
  end

  // Registered grant, selects and lock flag; everything holds while hready=0.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant       <= 3'b001;
      hmaster      <= MASTER1;
      hmaster_data <= MASTER1;
      hmastlock    <= 1'b0;
      tenure_cnt   <= '0;
      rr_ptr       <= 2'd2;
    end else if (hready) begin
      hgrant       <= 3'b001 << grant_idx_nxt;
      hmaster      <= enc_master(owner_idx);
      hmaster_data <= hmaster;
      hmastlock    <= hlock[owner_idx] & hgrant[owner_idx];
      tenure_cnt   <= tenure_cnt_nxt;
      rr_ptr       <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Testbench for ahb_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_ahb_bus_arbiter;

  localparam int unsigned MAX_TENURE = 16;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [2:0] hbusreq;
  logic [2:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [2:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: master indices 0..2 equal their hmaster codes.
  int m_grant, m_master, m_mdata, m_lock, m_cnt, m_ptr;

  ahb_bus_arbiter #(
    .MASTER1(2'b00), .MASTER2(2'b01), .MASTER3(2'b10), .MAX_TENURE(MAX_TENURE)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the arbitration rules, applied to the sampled inputs.
  task automatic model_step();
    int  ng;
    int  masked;
    bit  hit;
    bit  others;
    if (hreset) begin
      m_grant = 0; m_master = 0; m_mdata = 0; m_lock = 0; m_cnt = 0; m_ptr = 2;
    end else if (hready) begin
      others   = (int'(hbusreq) & ~(1 << m_grant)) != 0;
      m_mdata  = m_master;
      m_master = m_grant;
      m_lock   = int'(hlock[m_grant]);
      ng       = m_grant;
      if (!(htrans == 2'b01 || htrans == 2'b11)) begin
        if (!(hbusreq[m_grant] && hlock[m_grant])) begin
          masked = int'(hbusreq);
          if (m_cnt >= int'(MAX_TENURE) - 1 && !hlock[m_grant]) masked &= ~(1 << m_grant);
          hit = 1'b0;
          for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (!hit && ((masked >> c) & 1) == 1) begin
              hit = 1'b1;
              ng  = c;
            end
          end
          if (hit) begin
            if (ng != m_grant) m_ptr = ng;
          end else if (hbusreq[m_grant]) begin
            ng = m_grant;
          end else begin
            ng = 0;
          end
        end
      end
      if (ng != m_grant)  m_cnt = 0;
      else if (others)    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else                m_cnt = 0;
      m_grant = ng;
    end
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic step();
    logic [2:0] exp_grant;
    @(posedge hclk);
    model_step();
    #1;
    exp_grant = 3'b001 << m_grant;
    chk("hgrant",       32'(hgrant),       32'(exp_grant));
    chk("hmaster",      32'(hmaster),      32'(m_master));
    chk("hmaster_data", 32'(hmaster_data), 32'(m_mdata));
    chk("hmastlock",    32'(hmastlock),    32'(m_lock));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hgrant"},    32'(hgrant),       32'h1);
    chk({tag, "_hmaster"},   32'(hmaster),      32'h0);
    chk({tag, "_hmdata"},    32'(hmaster_data), 32'h0);
    chk({tag, "_hmastlock"}, 32'(hmastlock),    32'h0);
  endtask

  initial begin
    hreset = 1'b1; hbusreq = 3'b000; hlock = 3'b000; htrans = 2'b00; hready = 1'b1;
    m_grant = 0; m_master = 0; m_mdata = 0; m_lock = 0; m_cnt = 0; m_ptr = 2;

    // Reset for two cycles, then idle.
    repeat (2) begin step(); chk_reset_vals("reset"); end
    #3 hreset = 1'b0;
    repeat (4) begin step(); chk_reset_vals("idle"); end

    // Tenure: master1 keeps the bus for 16 cycles against master2, then yields.
    #3 hbusreq = 3'b011; htrans = 2'b10;
    for (int k = 1; k <= 15; k++) begin step(); chk("tenure_hold", 32'(hgrant), 32'h1); end
    step(); chk("tenure_release", 32'(hgrant), 32'h2);
    repeat (2) step();

    // Reset in the middle of traffic returns straight to reset values.
    #3 hreset = 1'b1;
    step(); chk_reset_vals("midreset");
    #3 hreset = 1'b0;

    // Round robin from a master3 owner.
    #3 hbusreq = 3'b100;
    step(); chk("rr_m3", 32'(hgrant), 32'h4);
    #3 hbusreq = 3'b111;
    step(); chk("rr_1", 32'(hgrant), 32'h1);
    step(); chk("rr_2", 32'(hgrant), 32'h2);
    step(); chk("rr_3", 32'(hgrant), 32'h4);
    step(); chk("rr_4", 32'(hgrant), 32'h1);
    step(); chk("rr_5", 32'(hgrant), 32'h2);

    // Burst protection: master2 keeps the grant during SEQ beats.
    #3 hbusreq = 3'b101; htrans = 2'b11;
    repeat (4) begin step(); chk("burst_hold", 32'(hgrant), 32'h2); end
    #3 htrans = 2'b10;
    step(); chk("burst_end", 32'(hgrant), 32'h4);

    // Wait states freeze everything; first ready edge moves grant to master2.
    #3 hbusreq = 3'b001;
    step(); chk("wait_pre", 32'(hgrant), 32'h1);
    #3 hready = 1'b0; hbusreq = 3'b010;
    repeat (3) begin step(); chk("wait_hold", 32'(hgrant), 32'h1); end
    #3 hready = 1'b1;
    step(); chk("wait_release", 32'(hgrant), 32'h2);

    // Lock: master1 locked beyond the tenure limit, then releases to master2.
    #3 hreset = 1'b1;
    step();
    #3 hreset = 1'b0; hbusreq = 3'b011; hlock = 3'b001; htrans = 2'b10;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("lock_grant", 32'(hgrant), 32'h1);
      chk("lock_mastlock", 32'(hmastlock), 32'h1);
    end
    #3 hlock = 3'b000;
    step(); chk("lock_drop", 32'(hgrant), 32'h2);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      #3;
      hreset  = ($urandom_range(0, 99) == 0);
      hbusreq = 3'($urandom_range(0, 7));
      hlock   = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      htrans  = 2'($urandom_range(0, 3));
      hready  = ($urandom_range(0, 4) != 0);
      step();
      chk("rand_onehot", 32'($countones(hgrant)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
